// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Readback decoder for the multiplexed 4-digit 7-segment bus of the stopwatch
// display. Samples the active-low anode/cathode lines, rejects inter-digit
// ghosting with a stability filter, decodes each settled digit to BCD and
// reassembles complete MM:SS frames into binary minutes/seconds.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] anode_in,
  input  logic [6:0] seg_in,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       frame_valid,
  output logic       decode_err,
  output logic [7:0] err_count,
  output logic       scan_lost
);

  localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [TCW-1:0] TIMEOUT_VAL = TCW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // {anode[3:0], seg[6:0]}; all ones is the blank bus
  logic [10:0]    sync1_q, sync2_q, cand_q;
  logic [1:0]     state_q, state_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic           changed;
  logic           eval;

  logic [3:0]     anode;
  logic [6:0]     seg;
  logic [3:0]     bcd;
  logic           pat_ok;
  logic           anode_idle;
  logic           anode_one;
  logic           dig_ok;
  logic           dig_bad;

  logic [15:0]    digits_q, digits_d;
  logic [3:0]     mask_q, mask_d;
  logic [3:0]     mask_set;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           lost_q, lost_d;
  logic           frame_pend_q, frame_pend_d;
  logic           err_pend_q;
  logic           frame_ok;
  logic           any_err;

  logic [5:0]     minutes_q, seconds_q;
  logic           frame_valid_q, decode_err_q;
  logic [7:0]     err_count_q;

  // Two-flop synchronizer followed by the candidate (previous sample) register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      cand_q  <= '1;
    end else begin
      sync1_q <= {anode_in, seg_in};
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
    end
  end

  assign changed = (sync2_q != cand_q);
  assign anode   = cand_q[10:7];
  assign seg     = cand_q[6:0];

  // Stability filter: count consecutive identical samples, evaluate once settled
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    eval    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (changed) begin
          state_d = ST_SETTLE;
          scnt_d  = SCW'(1);
        end
      end
      ST_SETTLE: begin
        if (changed) begin
          scnt_d = SCW'(1);
        end else if (scnt_q >= SETTLE_LAST) begin
          eval    = 1'b1;
          state_d = ST_HOLD;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + SCW'(1);
        end
      end
      ST_HOLD: begin
        if (changed) begin
          if (sync2_q[10:7] == 4'hF) begin
            state_d = ST_IDLE;
            scnt_d  = '0;
          end else begin
            state_d = ST_SETTLE;
            scnt_d  = SCW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        scnt_d  = '0;
      end
    endcase
  end

  // Active-low cathode pattern to BCD
  always_comb begin
    pat_ok = 1'b1;
    bcd    = 4'd0;
    case (seg)
      7'b0000001: bcd = 4'd0;
      7'b1001111: bcd = 4'd1;
      7'b0010010: bcd = 4'd2;
      7'b0000110: bcd = 4'd3;
      7'b1001100: bcd = 4'd4;
      7'b0100100: bcd = 4'd5;
      7'b0100000: bcd = 4'd6;
      7'b0001111: bcd = 4'd7;
      7'b0000000: bcd = 4'd8;
      7'b0000100: bcd = 4'd9;
      default:    pat_ok = 1'b0;
    endcase
  end

  assign anode_idle = (anode == 4'hF);
  assign anode_one  = (anode == 4'b0111) || (anode == 4'b1011) ||
                      (anode == 4'b1101) || (anode == 4'b1110);
  assign dig_ok     = eval && anode_one && pat_ok;
  assign dig_bad    = eval && !anode_idle && !(anode_one && pat_ok);
  assign mask_set   = mask_q | ~anode;

  // Digit slots, capture mask and scan-loss timeout
  always_comb begin
    digits_d     = digits_q;
    mask_d       = mask_q;
    to_cnt_d     = to_cnt_q;
    lost_d       = lost_q;
    frame_pend_d = 1'b0;
    if (dig_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (!anode[i]) digits_d[i*4 +: 4] = bcd;
      end
      to_cnt_d = '0;
      lost_d   = 1'b0;
      if (mask_set == 4'hF) begin
        // Frame complete: the mask restarts whether or not the range check passes
        mask_d       = 4'h0;
        frame_pend_d = 1'b1;
      end else begin
        mask_d = mask_set;
      end
    end else begin
      // A rejected digit forgets every slot whose anode was driven low
      if (dig_bad) mask_d = mask_q & anode;
      if (to_cnt_q != TIMEOUT_VAL) to_cnt_d = to_cnt_q + TCW'(1);
      if (to_cnt_d == TIMEOUT_VAL) begin
        lost_d = 1'b1;
        mask_d = 4'h0;
      end
    end
  end

  // Filter state, digit store and timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      scnt_q       <= '0;
      digits_q     <= '0;
      mask_q       <= 4'h0;
      to_cnt_q     <= TIMEOUT_VAL;
      lost_q       <= 1'b1;
      frame_pend_q <= 1'b0;
      err_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      digits_q     <= digits_d;
      mask_q       <= mask_d;
      to_cnt_q     <= to_cnt_d;
      lost_q       <= lost_d;
      frame_pend_q <= frame_pend_d;
      err_pend_q   <= dig_bad;
    end
  end

  // Tens digits must be 0..5 for a legal MM:SS frame
  assign frame_ok = (digits_q[15:12] <= 4'd5) && (digits_q[7:4] <= 4'd5);
  assign any_err  = err_pend_q || (frame_pend_q && !frame_ok);

  // Frame output stage and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minutes_q     <= 6'd0;
      seconds_q     <= 6'd0;
      frame_valid_q <= 1'b0;
      decode_err_q  <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      frame_valid_q <= frame_pend_q && frame_ok;
      decode_err_q  <= any_err;
      if (frame_pend_q && frame_ok) begin
        minutes_q <= {2'b00, digits_q[15:12]} * 6'd10 + {2'b00, digits_q[11:8]};
        seconds_q <= {2'b00, digits_q[7:4]} * 6'd10 + {2'b00, digits_q[3:0]};
      end
      if (any_err && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign minutes     = minutes_q;
  assign seconds     = seconds_q;
  assign frame_valid = frame_valid_q;
  assign decode_err  = decode_err_q;
  assign err_count   = err_count_q;
  assign scan_lost   = lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
// Directed scan sequences for seg_scan_decoder; expected frames are queued as
// stimulus is driven and popped when frame_valid is seen.
module tb_seg_scan_decoder;

  localparam int unsigned SETTLE = 16;
  localparam int unsigned TMO    = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] anode_in;
  logic [6:0] seg_in;
  logic [5:0] minutes, seconds;
  logic       frame_valid, decode_err, scan_lost;
  logic [7:0] err_count;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .anode_in   (anode_in),
    .seg_in     (seg_in),
    .minutes    (minutes),
    .seconds    (seconds),
    .frame_valid(frame_valid),
    .decode_err (decode_err),
    .err_count  (err_count),
    .scan_lost  (scan_lost)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] m; logic [5:0] s; } frame_t;
  frame_t exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int frames_seen = 0;
  int derr_seen = 0;
  int fv_cyc = 0;
  int lost_rise_cyc = 0;
  int lost_fall_cyc = 0;
  int c_first = 0;
  int c_last = 0;
  int err_exp = 0;
  int derr_exp = 0;
  logic prev_fv = 1'b0;
  logic prev_de = 1'b0;
  logic prev_lost = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic frame_t mk(input int m, input int s);
    frame_t f;
    f.m = 6'(m);
    f.s = 6'(s);
    return f;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // One clock: sample 1 time unit after the edge and score any frame
  task automatic tick();
    frame_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_valid === 1'b1) begin
      frames_seen++;
      fv_cyc = cyc;
      check("fv_width", 32'(prev_fv), 0);
      tests_run++;
      assert (exp_q.size() > 0) else begin
        tests_failed++;
        $error("FAIL unexpected_frame: observed %0d:%0d expected none", minutes, seconds);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("frame_min", 32'(minutes), 32'(e.m));
        check("frame_sec", 32'(seconds), 32'(e.s));
      end
    end
    if (decode_err === 1'b1) begin
      derr_seen++;
      check("de_width", 32'(prev_de), 0);
    end
    if (prev_lost === 1'b0 && scan_lost === 1'b1) lost_rise_cyc = cyc;
    if (prev_lost === 1'b1 && scan_lost === 1'b0) lost_fall_cyc = cyc;
    prev_fv   = frame_valid;
    prev_de   = decode_err;
    prev_lost = scan_lost;
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] sg, input int n);
    anode_in = an;
    seg_in   = sg;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One digit followed by a short blank gap
  task automatic digit(input logic [3:0] an, input logic [6:0] sg, input int hold);
    show(an, sg, hold);
    show(4'hF, 7'h7F, 5);
  endtask

  task automatic scan_frame(input int m, input int s, input int hold);
    c_first = cyc;
    digit(4'b0111, seg_of(m / 10), hold);
    digit(4'b1011, seg_of(m % 10), hold);
    digit(4'b1101, seg_of(s / 10), hold);
    c_last = cyc;
    digit(4'b1110, seg_of(s % 10), hold);
  endtask

  initial begin
    int c;
    rst_n    = 1'b0;
    anode_in = 4'hF;
    seg_in   = 7'h7F;
    repeat (3) tick();
    check("rst_minutes", 32'(minutes), 0);
    check("rst_seconds", 32'(seconds), 0);
    check("rst_frame_valid", 32'(frame_valid), 0);
    check("rst_decode_err", 32'(decode_err), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_scan_lost", 32'(scan_lost), 1);
    rst_n = 1'b1;
    tick();

    // 12:34 with exact capture and frame latency
    exp_q.push_back(mk(12, 34));
    scan_frame(12, 34, 40);
    check("first_capture_latency", 32'(lost_fall_cyc - c_first), SETTLE + 2);
    check("frame_latency", 32'(fv_cyc - c_last), SETTLE + 3);
    check("frames_after_1234", 32'(frames_seen), 1);
    check("minutes_1234", 32'(minutes), 12);
    check("seconds_1234", 32'(seconds), 34);
    check("err_after_1234", 32'(err_count), 0);
    check("lost_after_1234", 32'(scan_lost), 0);

    // Min ones held too briefly: slot stays empty until rescanned
    digit(4'b0111, seg_of(1), 40);
    digit(4'b1011, seg_of(2), 10);
    digit(4'b1101, seg_of(3), 40);
    digit(4'b1110, seg_of(4), 40);
    check("no_frame_short_digit", 32'(frames_seen), 1);
    exp_q.push_back(mk(15, 34));
    digit(4'b1011, seg_of(5), 40);
    check("frame_after_rescan", 32'(frames_seen), 2);

    // Blank cathodes on min ones: digit error, then recovery
    digit(4'b0111, seg_of(2), 40);
    digit(4'b1011, 7'h7F, 40);
    err_exp = sat_inc(err_exp); derr_exp++;
    digit(4'b1101, seg_of(4), 40);
    digit(4'b1110, seg_of(5), 40);
    check("no_frame_bad_pattern", 32'(frames_seen), 2);
    check("err_bad_pattern", 32'(err_count), 32'(err_exp));
    check("derr_bad_pattern", 32'(derr_seen), 32'(derr_exp));
    exp_q.push_back(mk(23, 45));
    digit(4'b1011, seg_of(3), 40);
    check("frame_after_fix", 32'(frames_seen), 3);

    // Sec tens 7: frame range error, outputs hold, mask restarts
    scan_frame(12, 74, 40);
    err_exp = sat_inc(err_exp); derr_exp++;
    check("no_frame_range", 32'(frames_seen), 3);
    check("err_range", 32'(err_count), 32'(err_exp));
    check("derr_range", 32'(derr_seen), 32'(derr_exp));
    check("minutes_hold", 32'(minutes), 23);
    check("seconds_hold", 32'(seconds), 45);
    digit(4'b0111, seg_of(6), 40);
    check("mask_cleared_after_range", 32'(frames_seen), 3);

    // Two anodes low
    digit(4'b0011, seg_of(1), 40);
    err_exp = sat_inc(err_exp); derr_exp++;
    check("err_two_anodes", 32'(err_count), 32'(err_exp));
    check("derr_two_anodes", 32'(derr_seen), 32'(derr_exp));

    // Scan loss: exactly TMO cycles after the last capture
    digit(4'b0111, seg_of(1), 40);
    digit(4'b1011, seg_of(2), 40);
    c = cyc;
    show(4'b1101, seg_of(3), 40);
    show(4'hF, 7'h7F, 1100);
    check("scan_lost_set", 32'(scan_lost), 1);
    check("scan_lost_delay", 32'(lost_rise_cyc - c), SETTLE + 2 + TMO);
    c = cyc;
    digit(4'b1110, seg_of(9), 40);
    check("scan_lost_clear_latency", 32'(lost_fall_cyc - c), SETTLE + 2);
    check("scan_lost_cleared", 32'(scan_lost), 0);
    check("mask_cleared_by_timeout", 32'(frames_seen), 3);
    exp_q.push_back(mk(59, 59));
    scan_frame(59, 59, 40);
    check("frame_5959", 32'(frames_seen), 4);
    check("minutes_5959", 32'(minutes), 59);

    // Error counter saturation
    for (int i = 0; i < 252; i++) begin
      show(4'b1110, (i % 2 == 0) ? 7'h7F : 7'h3F, 20);
      err_exp = sat_inc(err_exp); derr_exp++;
    end
    check("err_at_255", 32'(err_count), 32'(err_exp));
    for (int i = 0; i < 8; i++) begin
      show(4'b1110, (i % 2 == 0) ? 7'h7F : 7'h3F, 20);
      err_exp = sat_inc(err_exp); derr_exp++;
    end
    check("err_saturated", 32'(err_count), 255);
    check("derr_total", 32'(derr_seen), 32'(derr_exp));

    // Reset mid-SETTLE with a partial frame in the mask
    show(4'hF, 7'h7F, 5);
    digit(4'b0111, seg_of(0), 40);
    digit(4'b1011, seg_of(1), 40);
    digit(4'b1101, seg_of(0), 40);
    show(4'b1110, seg_of(2), 8);
    rst_n = 1'b0;
    #2;
    check("midrst_minutes", 32'(minutes), 0);
    check("midrst_seconds", 32'(seconds), 0);
    check("midrst_err_count", 32'(err_count), 0);
    check("midrst_scan_lost", 32'(scan_lost), 1);
    check("midrst_frame_valid", 32'(frame_valid), 0);
    check("midrst_decode_err", 32'(decode_err), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    show(4'b1110, seg_of(2), 40);
    check("no_frame_after_reset", 32'(frames_seen), 4);
    check("capture_after_reset", 32'(scan_lost), 0);
    exp_q.push_back(mk(1, 2));
    scan_frame(1, 2, 40);
    check("frame_after_reset", 32'(frames_seen), 5);
    check("err_after_reset", 32'(err_count), 0);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
